// File: rtl/ins_mem_if.sv
// Fetch and loader bus of the instruction memory.
// The memory owns the slave modport; the core and the program loader drive the master side.
interface ins_mem_if #(
   parameter int DATA_W = 19,
   parameter int ADDR_W = 16
);
   logic              ready;
   logic              fetch_req;
   logic [ADDR_W:0]   fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_err;
   logic              ld_we;
   logic [ADDR_W:0]   ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ack;
   logic              ld_err;

   modport slave (
      output ready, fetch_valid, fetch_data, fetch_err, ld_ack, ld_err,
      input  fetch_req, fetch_addr, ld_we, ld_addr, ld_data
   );

   modport master (
      input  ready, fetch_valid, fetch_data, fetch_err, ld_ack, ld_err,
      output fetch_req, fetch_addr, ld_we, ld_addr, ld_data
   );
endinterface

// File: rtl/ins_mem_dp.sv
// Instruction memory: one registered fetch port and one loader write port on a simple-dual-port array.
// An optional post-reset sweep zeroes every word before the core is allowed to fetch.
module ins_mem_dp #(
   parameter int DATA_W         = 19,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 1 << ADDR_W,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   ins_mem_if.slave bus
);
   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_READY} state_t;
   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_FWD} src_t;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] ram_rd_q;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              fetch_err_q, fetch_err_d;
   src_t              src_q, src_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
   logic              ld_ack_q, ld_ack_d;
   logic              ld_err_q, ld_err_d;

   logic              fetch_in, ld_in, fetch_acc, ld_acc, collide;
   logic              ram_we, ram_re;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] fetch_data_mux;

   // Range check uses the full ADDR_W+1 bits so non-power-of-2 depths are caught too.
   always_comb begin
      fetch_in  = bus.fetch_addr < DEPTH_L;
      ld_in     = bus.ld_addr < DEPTH_L;
      fetch_acc = ready_q & bus.fetch_req;
      ld_acc    = ready_q & bus.ld_we;
      collide   = fetch_acc & ld_acc & fetch_in & ld_in & (bus.fetch_addr == bus.ld_addr);
   end

   // The clear sweep and the loader share the single write port; the sweep only runs while not ready.
   always_comb begin
      ram_we    = (state_q == ST_CLEAR) | (ld_acc & ld_in);
      ram_waddr = (state_q == ST_CLEAR) ? cnt_q : bus.ld_addr[IDX_W-1:0];
      ram_wdata = (state_q == ST_CLEAR) ? '0 : bus.ld_data;
      ram_re    = fetch_acc & fetch_in & ~collide;
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      if (ram_re) begin
         ram_rd_q <= mem[bus.fetch_addr[IDX_W-1:0]];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_d   = '0;
         end
         ST_CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         ST_READY: state_d = ST_READY;
         default:  state_d = ST_INIT;
      endcase
      ready_d = (state_d == ST_READY);
   end

   // Output source is latched per accepted fetch, so data and error hold while no request arrives.
   always_comb begin
      fetch_valid_d = fetch_acc;
      fetch_err_d   = fetch_err_q;
      src_d         = src_q;
      fwd_data_d    = fwd_data_q;
      if (fetch_acc) begin
         fetch_err_d = ~fetch_in;
         if (!fetch_in) begin
            src_d = SRC_ZERO;
         end else if (collide) begin
            src_d      = SRC_FWD;
            fwd_data_d = bus.ld_data;
         end else begin
            src_d = SRC_RAM;
         end
      end
      ld_ack_d = ld_acc & ld_in;
      ld_err_d = ld_acc & ~ld_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_INIT;
         cnt_q         <= '0;
         ready_q       <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         src_q         <= SRC_ZERO;
         fwd_data_q    <= '0;
         ld_ack_q      <= 1'b0;
         ld_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_err_q   <= fetch_err_d;
         src_q         <= src_d;
         fwd_data_q    <= fwd_data_d;
         ld_ack_q      <= ld_ack_d;
         ld_err_q      <= ld_err_d;
      end
   end

   always_comb begin
      case (src_q)
         SRC_RAM: fetch_data_mux = ram_rd_q;
         SRC_FWD: fetch_data_mux = fwd_data_q;
         default: fetch_data_mux = '0;
      endcase
   end

   assign bus.ready       = ready_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_err   = fetch_err_q;
   assign bus.fetch_data  = fetch_data_mux;
   assign bus.ld_ack      = ld_ack_q;
   assign bus.ld_err      = ld_err_q;
endmodule

// File: tb/tb_ins_mem_dp.sv
// Bench for ins_mem_dp: a 16-word instance with clear-on-reset and a 12-word instance without,
// checked against word-array models updated from the fetch/write rules.
module tb_ins_mem_dp;
   logic clk;
   logic rst_n16, rst_n12;
   int   n_checks, n_fail;

   logic [18:0] m16 [16];
   logic [18:0] m12 [12];

   ins_mem_if #(.DATA_W(19), .ADDR_W(4)) b16 ();
   ins_mem_if #(.DATA_W(19), .ADDR_W(4)) b12 ();

   ins_mem_dp #(.DATA_W(19), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1)) dut16 (
      .clk(clk), .rst_n(rst_n16), .bus(b16.slave)
   );
   ins_mem_dp #(.DATA_W(19), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(0)) dut12 (
      .clk(clk), .rst_n(rst_n12), .bus(b12.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b16.fetch_req = 1'b0; b16.ld_we = 1'b0;
      b12.fetch_req = 1'b0; b12.ld_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n16 = 1'b0; rst_n12 = 1'b0;
      b16.fetch_req = 1'b1; b16.fetch_addr = 5'd1; b16.ld_we = 1'b1; b16.ld_addr = 5'd1; b16.ld_data = 19'h1;
      b12.fetch_req = 1'b1; b12.fetch_addr = 5'd1; b12.ld_we = 1'b1; b12.ld_addr = 5'd1; b12.ld_data = 19'h1;
      repeat (3) cyc();
      n_checks++;
      if ({b16.ready, b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset16: rdy=%b v=%b e=%b ack=%b lerr=%b data=%h, required all 0",
                  b16.ready, b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data);
      end
      n_checks++;
      if ({b12.ready, b12.fetch_valid, b12.fetch_err, b12.ld_ack, b12.ld_err, b12.fetch_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset12: rdy=%b v=%b e=%b ack=%b lerr=%b data=%h, required all 0",
                  b12.ready, b12.fetch_valid, b12.fetch_err, b12.ld_ack, b12.ld_err, b12.fetch_data);
      end
      $display("reset: both instances held in reset with requests asserted");
   endtask

   task automatic wait_ready16(input string tag);
      int n;
      n = 0;
      while (b16.ready !== 1'b1 && n < 100) begin
         cyc();
         n++;
         n_checks++;
         if ({b16.fetch_valid, b16.ld_ack, b16.ld_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_idle: v=%b ack=%b lerr=%b at cycle %0d, required 000",
                     tag, b16.fetch_valid, b16.ld_ack, b16.ld_err, n);
         end
      end
      n_checks++;
      if (n != 17) begin
         n_fail++;
         $display("FAIL %s_latency: ready after %0d cycles, required 17", tag, n);
      end
      $display("%s: ready after %0d cycles", tag, n);
   endtask

   task automatic test_clear();
      // Requests stay asserted through the whole sweep; late writes to 3 must not survive.
      b16.fetch_req = 1'b1; b16.fetch_addr = 5'd3;
      b16.ld_we = 1'b1; b16.ld_addr = 5'd3; b16.ld_data = 19'h55555;
      rst_n16 = 1'b1;
      wait_ready16("clear");
      idle_all();
      for (int i = 0; i < 16; i++) m16[i] = '0;
      for (int i = 0; i < 16; i++) begin
         b16.fetch_req = 1'b1; b16.fetch_addr = 5'(i);
         cyc();
         n_checks++;
         if ({b16.fetch_valid, b16.fetch_err, b16.fetch_data} !== {1'b1, 1'b0, 19'h0}) begin
            n_fail++;
            $display("FAIL clear_word%0d: v=%b e=%b data=%h, required v=1 e=0 data=0",
                     i, b16.fetch_valid, b16.fetch_err, b16.fetch_data);
         end
      end
      idle_all();
      $display("clear: swept fetch of 16 words");
   endtask

   task automatic test_no_clear();
      b12.fetch_req = 1'b1; b12.fetch_addr = 5'd0;
      b12.ld_we = 1'b1; b12.ld_addr = 5'd0; b12.ld_data = 19'h1;
      rst_n12 = 1'b1;
      cyc();
      n_checks++;
      if ({b12.ready, b12.fetch_valid, b12.ld_ack, b12.ld_err} !== 4'b1000) begin
         n_fail++;
         $display("FAIL noclear_ready: rdy=%b v=%b ack=%b lerr=%b, required 1000",
                  b12.ready, b12.fetch_valid, b12.ld_ack, b12.ld_err);
      end
      idle_all();
      for (int i = 0; i < 12; i++) begin
         m12[i] = 19'($urandom);
         b12.ld_we = 1'b1; b12.ld_addr = 5'(i); b12.ld_data = m12[i];
         cyc();
         n_checks++;
         if ({b12.ld_ack, b12.ld_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL init12_ack%0d: ack=%b lerr=%b, required ack=1 lerr=0", i, b12.ld_ack, b12.ld_err);
         end
      end
      idle_all();
      $display("no_clear: ready one cycle after release, 12 words loaded");
   endtask

   task automatic test_write_read();
      b16.ld_we = 1'b1; b16.ld_addr = 5'd5; b16.ld_data = 19'h7FFFF;
      m16[5] = 19'h7FFFF;
      cyc();
      n_checks++;
      if ({b16.ld_ack, b16.ld_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL wr5_ack: ack=%b lerr=%b, required ack=1 lerr=0", b16.ld_ack, b16.ld_err);
      end
      b16.ld_we = 1'b0; b16.fetch_req = 1'b1; b16.fetch_addr = 5'd5;
      cyc();
      n_checks++;
      if ({b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.fetch_data} !== {1'b1, 1'b0, 1'b0, 19'h7FFFF}) begin
         n_fail++;
         $display("FAIL rd5: v=%b e=%b ack=%b data=%h, required v=1 e=0 ack=0 data=7ffff",
                  b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.fetch_data);
      end
      idle_all();
      cyc();
      n_checks++;
      if ({b16.fetch_valid, b16.fetch_err, b16.fetch_data} !== {1'b0, 1'b0, 19'h7FFFF}) begin
         n_fail++;
         $display("FAIL hold5: v=%b e=%b data=%h, required v=0 e=0 data=7ffff held",
                  b16.fetch_valid, b16.fetch_err, b16.fetch_data);
      end
      $display("write_read: 7ffff @5 written and read back");
   endtask

   task automatic test_collision();
      b16.ld_we = 1'b1; b16.ld_addr = 5'd9; b16.ld_data = 19'h12345;
      b16.fetch_req = 1'b1; b16.fetch_addr = 5'd9;
      m16[9] = 19'h12345;
      cyc();
      n_checks++;
      if ({b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.fetch_data} !== {1'b1, 1'b0, 1'b1, 19'h12345}) begin
         n_fail++;
         $display("FAIL collide9: v=%b e=%b ack=%b data=%h, required v=1 e=0 ack=1 data=12345",
                  b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.fetch_data);
      end
      b16.ld_we = 1'b0;
      cyc();
      n_checks++;
      if ({b16.fetch_valid, b16.fetch_data} !== {1'b1, 19'h12345}) begin
         n_fail++;
         $display("FAIL reread9: v=%b data=%h, required v=1 data=12345", b16.fetch_valid, b16.fetch_data);
      end
      idle_all();
      $display("collision: write-first forwarding @9");
   endtask

   task automatic test_oor12();
      b12.fetch_req = 1'b1; b12.fetch_addr = 5'd12;
      cyc();
      n_checks++;
      if ({b12.fetch_valid, b12.fetch_err, b12.fetch_data} !== {1'b1, 1'b1, 19'h0}) begin
         n_fail++;
         $display("FAIL oor_fetch12: v=%b e=%b data=%h, required v=1 e=1 data=0",
                  b12.fetch_valid, b12.fetch_err, b12.fetch_data);
      end
      b12.fetch_req = 1'b0;
      b12.ld_we = 1'b1; b12.ld_addr = 5'd13; b12.ld_data = 19'h2AAAA;
      cyc();
      n_checks++;
      if ({b12.ld_ack, b12.ld_err} !== 2'b01) begin
         n_fail++;
         $display("FAIL oor_write13: ack=%b lerr=%b, required ack=0 lerr=1", b12.ld_ack, b12.ld_err);
      end
      b12.ld_addr = 5'd31; b12.fetch_req = 1'b1; b12.fetch_addr = 5'd31;
      cyc();
      n_checks++;
      if ({b12.fetch_valid, b12.fetch_err, b12.fetch_data, b12.ld_ack, b12.ld_err} !== {1'b1, 1'b1, 19'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL oor_both31: v=%b e=%b data=%h ack=%b lerr=%b, required v=1 e=1 data=0 ack=0 lerr=1",
                  b12.fetch_valid, b12.fetch_err, b12.fetch_data, b12.ld_ack, b12.ld_err);
      end
      b12.ld_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         b12.fetch_req = 1'b1; b12.fetch_addr = 5'(i);
         cyc();
         n_checks++;
         if ({b12.fetch_valid, b12.fetch_err, b12.fetch_data} !== {1'b1, 1'b0, m12[i]}) begin
            n_fail++;
            $display("FAIL oor_intact%0d: v=%b e=%b data=%h, required v=1 e=0 data=%h",
                     i, b12.fetch_valid, b12.fetch_err, b12.fetch_data, m12[i]);
         end
      end
      idle_all();
      $display("oor12: out-of-range fetch/write flagged, array intact");
   endtask

   task automatic test_random();
      logic        ev16, ee16, ea16, el16, ev12, ee12, ea12, el12;
      logic [18:0] ed16, ed12;
      ee16 = 1'b0; ed16 = '0; ee12 = 1'b0; ed12 = '0;
      for (int i = 0; i < 300; i++) begin
         logic        fr, we;
         logic [4:0]  fa, la;
         logic [18:0] d;
         fr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         fa = 5'($urandom_range(0, 18));
         la = 5'($urandom_range(0, 18));
         if ($urandom_range(0, 3) == 0) la = fa;
         d  = 19'($urandom);
         b16.fetch_req = fr; b16.fetch_addr = fa; b16.ld_we = we; b16.ld_addr = la; b16.ld_data = d;
         ev16 = fr;
         if (fr) begin
            if (fa < 16) begin ee16 = 1'b0; ed16 = (we && la == fa) ? d : m16[fa[3:0]]; end
            else begin ee16 = 1'b1; ed16 = '0; end
         end
         ea16 = we && la < 16;
         el16 = we && la >= 16;
         if (ea16) m16[la[3:0]] = d;

         fr = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         fa = 5'($urandom_range(0, 14));
         la = 5'($urandom_range(0, 14));
         if ($urandom_range(0, 3) == 0) la = fa;
         d  = 19'($urandom);
         if (i == 0) fr = 1'b1;
         b12.fetch_req = fr; b12.fetch_addr = fa; b12.ld_we = we; b12.ld_addr = la; b12.ld_data = d;
         ev12 = fr;
         if (fr) begin
            if (fa < 12) begin ee12 = 1'b0; ed12 = (we && la == fa) ? d : m12[int'(fa)]; end
            else begin ee12 = 1'b1; ed12 = '0; end
         end
         ea12 = we && la < 12;
         el12 = we && la >= 12;
         if (ea12) m12[int'(la)] = d;

         cyc();
         n_checks++;
         if ({b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data} !== {ev16, ee16, ea16, el16, ed16}) begin
            n_fail++;
            $display("FAIL rand16_%0d: v=%b e=%b ack=%b lerr=%b data=%h, required v=%b e=%b ack=%b lerr=%b data=%h",
                     i, b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data,
                     ev16, ee16, ea16, el16, ed16);
         end
         n_checks++;
         if ({b12.fetch_valid, b12.fetch_err, b12.ld_ack, b12.ld_err, b12.fetch_data} !== {ev12, ee12, ea12, el12, ed12}) begin
            n_fail++;
            $display("FAIL rand12_%0d: v=%b e=%b ack=%b lerr=%b data=%h, required v=%b e=%b ack=%b lerr=%b data=%h",
                     i, b12.fetch_valid, b12.fetch_err, b12.ld_ack, b12.ld_err, b12.fetch_data,
                     ev12, ee12, ea12, el12, ed12);
         end
      end
      idle_all();
      $display("random: 300 mixed cycles on both instances");
   endtask

   task automatic test_reset_mid_clear();
      b16.ld_we = 1'b1; b16.ld_addr = 5'd15; b16.ld_data = 19'h2ABCD;
      cyc();
      b16.ld_addr = 5'd2;
      cyc();
      idle_all();
      rst_n16 = 1'b0;
      cyc();
      rst_n16 = 1'b1;
      repeat (8) cyc();
      rst_n16 = 1'b0;
      #2;
      n_checks++;
      if ({b16.ready, b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL midclear_async: rdy=%b v=%b e=%b ack=%b lerr=%b data=%h, required all 0",
                  b16.ready, b16.fetch_valid, b16.fetch_err, b16.ld_ack, b16.ld_err, b16.fetch_data);
      end
      cyc();
      rst_n16 = 1'b1;
      wait_ready16("restart");
      idle_all();
      for (int i = 0; i < 16; i++) m16[i] = '0;
      for (int k = 0; k < 3; k++) begin
         logic [4:0] a;
         a = (k == 0) ? 5'd15 : ((k == 1) ? 5'd2 : 5'd9);
         b16.fetch_req = 1'b1; b16.fetch_addr = a;
         cyc();
         n_checks++;
         if ({b16.fetch_valid, b16.fetch_err, b16.fetch_data} !== {1'b1, 1'b0, m16[a[3:0]]}) begin
            n_fail++;
            $display("FAIL restart_word%0d: v=%b e=%b data=%h, required v=1 e=0 data=0",
                     a, b16.fetch_valid, b16.fetch_err, b16.fetch_data);
         end
      end
      idle_all();
      $display("reset_mid_clear: aborted at cnt=7, full sweep repeated");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      b16.fetch_addr = '0; b16.ld_addr = '0; b16.ld_data = '0;
      b12.fetch_addr = '0; b12.ld_addr = '0; b12.ld_data = '0;
      test_reset();
      test_clear();
      test_no_clear();
      test_write_read();
      test_collision();
      test_oor12();
      test_random();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
